// File: rtl/screen_writer_pkg.sv
// Shared definitions for the Spectrum bitmap writer and the video scan-out side.
//   state_t      : writer FSM states
//   SCREEN_*     : character grid geometry
//   BITMAP_BYTES : size of the pixel bitmap (attribute area excluded)
//   bitmap_addr  : character row/line/column to interleaved bitmap address
//   bit_reverse8 : swap pixel order between font ROM (MSB left) and screen (LSB left)
package screen_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GLYPH = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int SCREEN_COLS  = 32;
  localparam int SCREEN_ROWS  = 24;
  localparam int BITMAP_BYTES = 6144;

  // Spectrum interleave: third of screen, pixel line in cell, char row in third, column.
  function automatic logic [12:0] bitmap_addr(input logic [4:0] row,
                                              input logic [2:0] line,
                                              input logic [4:0] col);
    return {row[4:3], line, row[2:0], col};
  endfunction

  function automatic logic [7:0] bit_reverse8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = d[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/screen_writer.sv
// Glyph plotter and bitmap clearer for the 6144-byte Spectrum bitmap.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   cmd_valid/ready   : command handshake (ready while idle)
//   cmd_op            : 0 = put glyph, 1 = clear bitmap
//   cmd_char/col/row  : glyph code and character cell
//   cmd_invert        : invert glyph pixels
//   font_addr         : {char, line} to external synchronous font ROM
//   font_data         : ROM line, bit 7 = leftmost pixel, one cycle after address
//   mem_addr/data/we  : registered screen memory write port, bit 0 = leftmost pixel
//   busy              : command in progress
module screen_writer #(
  parameter logic [7:0] CLEAR_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [7:0]  cmd_char,
  input  logic [4:0]  cmd_col,
  input  logic [4:0]  cmd_row,
  input  logic        cmd_invert,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  output logic        busy
);
  import screen_writer_pkg::*;

  state_t      state;
  logic [12:0] cnt;
  logic [7:0]  char_q;
  logic [4:0]  col_q;
  logic [4:0]  row_q;
  logic        invert_q;

  logic [12:0] cnt_inc;
  logic [12:0] cnt_dec;

  assign cnt_inc   = cnt + 13'd1;
  assign cnt_dec   = cnt - 13'd1;
  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  // In GLYPH, cnt holds (edge index - 1). The ROM address for line L is issued
  // at edge L and its data is registered into the write port at edge L+2, so
  // the write for line cnt-1 happens while the ROM address runs two lines ahead.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      char_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      invert_q  <= 1'b0;
      font_addr <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (cmd_valid) begin
            char_q   <= cmd_char;
            col_q    <= cmd_col;
            row_q    <= cmd_row;
            invert_q <= cmd_invert;
            cnt      <= '0;
            if (cmd_op) begin
              state <= CLEAR;
            end else if (cmd_row < 5'(SCREEN_ROWS)) begin
              state     <= GLYPH;
              font_addr <= {cmd_char, 3'd0};
            end
            // Glyphs aimed below the last character row are silently dropped.
          end
        end

        GLYPH: begin
          cnt <= cnt_inc;
          if (cnt < 13'd7) begin
            font_addr <= {char_q, cnt_inc[2:0]};
          end
          if (cnt >= 13'd1 && cnt <= 13'd8) begin
            mem_we   <= 1'b1;
            mem_addr <= bitmap_addr(row_q, cnt_dec[2:0], col_q);
            mem_data <= bit_reverse8(font_data) ^ {8{invert_q}};
          end else begin
            mem_we <= 1'b0;
          end
          if (cnt == 13'd9) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end

        CLEAR: begin
          if (cnt < 13'(BITMAP_BYTES)) begin
            mem_we   <= 1'b1;
            mem_addr <= cnt;
            mem_data <= CLEAR_BYTE;
            cnt      <= cnt_inc;
          end else begin
            mem_we <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
          end
        end

        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_screen_writer.sv
// Directed self-checking bench for screen_writer with a behavioural font ROM.
module tb_screen_writer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [7:0]  cmd_char;
  logic [4:0]  cmd_col;
  logic [4:0]  cmd_row;
  logic        cmd_invert;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        busy;

  screen_writer #(.CLEAR_BYTE(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_char   (cmd_char),
    .cmd_col    (cmd_col),
    .cmd_row    (cmd_row),
    .cmd_invert (cmd_invert),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Font ROM: char 0x41 is an asymmetric test glyph, 0x42 is solid 0xF0,
  // everything else is a fixed scramble of the address.
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    if (a[10:3] == 8'h41) begin
      case (a[2:0])
        3'd0: return 8'h10;
        3'd1: return 8'h80;
        3'd2: return 8'hC0;
        3'd3: return 8'h0E;
        3'd4: return 8'h81;
        3'd5: return 8'h24;
        3'd6: return 8'h31;
        default: return 8'h07;
      endcase
    end else if (a[10:3] == 8'h42) begin
      return 8'hF0;
    end else begin
      return a[7:0] ^ 8'hA5;
    end
  endfunction

  always @(posedge clk) font_data <= rom_fn(font_addr);

  int total = 0;
  int passed = 0;
  int failed = 0;
  int wr_count = 0;
  int bad_addr = 0;
  int seq_err;
  logic [12:0] got_addr [8];
  logic [7:0]  got_data [8];

  always @(negedge clk) begin
    if (reset && mem_we) begin
      wr_count++;
      if (mem_addr >= 13'd6144) bad_addr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op, input logic [7:0] ch, input logic [4:0] col,
                       input logic [4:0] row, input logic inv);
    cmd_op = op; cmd_char = ch; cmd_col = col; cmd_row = row; cmd_invert = inv;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called just after the acceptance edge; walks edges 1..10 of a glyph.
  task automatic glyph_tail(input logic [7:0] ch);
    logic exp_we;
    seq_err = 0;
    if (font_addr !== {ch, 3'd0}) seq_err++;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k <= 7 && font_addr !== {ch, 3'(k)}) seq_err++;
      exp_we = (k >= 2 && k <= 9);
      if (mem_we !== exp_we) seq_err++;
      if (exp_we) begin
        got_addr[k-2] = mem_addr;
        got_data[k-2] = mem_data;
      end
      if (cmd_ready !== (k == 10)) seq_err++;
    end
  endtask

  logic [12:0] exp_a41 [8];
  logic [7:0]  exp_d41 [8];
  int wc;

  initial begin
    exp_d41 = '{8'h08, 8'h01, 8'h03, 8'h70, 8'h81, 8'h24, 8'h8C, 8'hE0};
    exp_a41 = '{13'h0000, 13'h0100, 13'h0200, 13'h0300, 13'h0400, 13'h0500, 13'h0600, 13'h0700};
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_char = '0;
    cmd_col = '0; cmd_row = '0; cmd_invert = 1'b0;
    tick(); tick();
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_font", font_addr, 0);
    reset = 1'b1;
    tick();

    // Glyph 0x41 at col 0 row 0
    wc = wr_count;
    issue(1'b0, 8'h41, 5'd0, 5'd0, 1'b0);
    check("g41_busy", busy, 1);
    glyph_tail(8'h41);
    check("g41_seq", seq_err, 0);
    check("g41_l1_addr", got_addr[1], 13'h0100);
    check("g41_l1_data", got_data[1], 8'h01);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("g41_addr%0d", i), got_addr[i], exp_a41[i]);
      check($sformatf("g41_data%0d", i), got_data[i], exp_d41[i]);
    end
    check("g41_count", wr_count - wc, 8);

    // Address corners
    issue(1'b0, 8'h43, 5'd31, 5'd23, 1'b0);
    glyph_tail(8'h43);
    check("r23_seq", seq_err, 0);
    check("r23_l0_addr", got_addr[0], 13'h10FF);
    check("r23_l7_addr", got_addr[7], 13'h17FF);
    check("r23_l7_data", got_data[7], 8'h5D);
    issue(1'b0, 8'h43, 5'd0, 5'd8, 1'b0);
    glyph_tail(8'h43);
    check("r8_seq", seq_err, 0);
    check("r8_l0_addr", got_addr[0], 13'h0800);
    check("r8_l1_addr", got_addr[1], 13'h0900);
    check("r8_l1_data", got_data[1], 8'h3D);

    // Invert
    issue(1'b0, 8'h42, 5'd2, 5'd1, 1'b1);
    glyph_tail(8'h42);
    check("inv1_seq", seq_err, 0);
    check("inv1_addr3", got_addr[3], 13'h0322);
    check("inv1_data3", got_data[3], 8'hF0);
    issue(1'b0, 8'h42, 5'd2, 5'd1, 1'b0);
    glyph_tail(8'h42);
    check("inv0_data0", got_data[0], 8'h0F);

    // Dropped glyph on row 25 followed back-to-back by a valid one
    wc = wr_count;
    cmd_op = 1'b0; cmd_char = 8'h41; cmd_col = 5'd3; cmd_row = 5'd25; cmd_invert = 1'b0;
    cmd_valid = 1'b1;
    tick();
    check("drop_ready", cmd_ready, 1);
    check("drop_we", mem_we, 0);
    cmd_char = 8'h42; cmd_col = 5'd5; cmd_row = 5'd0;
    tick();
    cmd_valid = 1'b0;
    check("b2b_busy", busy, 1);
    glyph_tail(8'h42);
    check("b2b_seq", seq_err, 0);
    check("b2b_addr0", got_addr[0], 13'h0005);
    check("b2b_data0", got_data[0], 8'h0F);
    check("b2b_count", wr_count - wc, 8);

    // Full clear
    issue(1'b1, 8'h00, 5'd0, 5'd0, 1'b0);
    check("clr_ready0", cmd_ready, 0);
    check("clr_we0", mem_we, 0);
    wc = wr_count;
    seq_err = 0;
    for (int k = 1; k <= 6144; k++) begin
      tick();
      if (!(mem_we === 1'b1 && mem_addr === 13'(k - 1) && mem_data === 8'h00 && cmd_ready === 1'b0))
        seq_err++;
    end
    check("clr_seq", seq_err, 0);
    tick();
    check("clr_we_end", mem_we, 0);
    check("clr_ready_end", cmd_ready, 1);
    check("clr_count", wr_count - wc, 6144);
    check("clr_bad_addr", bad_addr, 0);

    // Reset in the middle of a glyph
    issue(1'b0, 8'h41, 5'd0, 5'd0, 1'b0);
    repeat (5) tick();
    check("mid_we_before", mem_we, 1);
    reset = 1'b0;
    #1;
    check("mid_we", mem_we, 0);
    check("mid_ready", cmd_ready, 1);
    check("mid_addr", mem_addr, 0);
    check("mid_font", font_addr, 0);
    wc = wr_count;
    tick();
    reset = 1'b1;
    repeat (12) tick();
    check("mid_no_writes", wr_count - wc, 0);
    check("mid_ready_after", cmd_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
